// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debouncing.
// Emits a one-cycle shift strobe for digits and a func strobe for A-D, *, #.
module keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       shift,
  output logic       func,
  output logic       key_held
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      col_reg, col_next;
  logic [1:0]      row_reg, row_next;
  logic [SW-1:0]   scan_cnt_reg, scan_cnt_next;
  logic [DW-1:0]   deb_cnt_reg, deb_cnt_next;
  logic [3:0]      key_reg, key_next;
  logic            shift_reg, shift_next;
  logic            func_reg, func_next;
  logic [3:0]      row_meta_reg, rs_reg;

  logic            hit;
  logic [1:0]      hit_row;
  logic [3:0]      cand_pat;
  logic [3:0]      code;

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    if (c == 2'd3)
      k = 4'd10 + {2'b00, r};
    else if (r == 2'd3)
      k = (c == 2'd0) ? 4'd14 : ((c == 2'd1) ? 4'd0 : 4'd15);
    else
      k = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    return k;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_reg <= 4'hF;
      rs_reg       <= 4'hF;
    end else begin
      row_meta_reg <= row_n;
      rs_reg       <= row_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= SCAN;
      col_reg      <= 2'd0;
      row_reg      <= 2'd0;
      scan_cnt_reg <= '0;
      deb_cnt_reg  <= '0;
      key_reg      <= 4'd0;
      shift_reg    <= 1'b0;
      func_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      scan_cnt_reg <= scan_cnt_next;
      deb_cnt_reg  <= deb_cnt_next;
      key_reg      <= key_next;
      shift_reg    <= shift_next;
      func_reg     <= func_next;
    end
  end

  // Exactly one row low is a valid candidate; anything else is idle or ghosting.
  always_comb begin
    hit     = 1'b1;
    hit_row = 2'd0;
    case (rs_reg)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  assign cand_pat = ~(4'b0001 << row_reg);
  assign code     = keymap(row_reg, col_reg);

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    scan_cnt_next = scan_cnt_reg;
    deb_cnt_next  = deb_cnt_reg;
    key_next      = key_reg;
    shift_next    = 1'b0;
    func_next     = 1'b0;
    case (state_reg)
      SCAN: begin
        if (scan_cnt_reg == SCAN_LAST) begin
          scan_cnt_next = '0;
          if (hit) begin
            row_next     = hit_row;
            deb_cnt_next = '0;
            state_next   = DEBOUNCE;
          end else begin
            col_next = col_reg + 2'd1;
          end
        end else begin
          scan_cnt_next = scan_cnt_reg + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs_reg == cand_pat) begin
          if (deb_cnt_reg == DEB_LAST) begin
            state_next = PRESSED;
            key_next   = code;
            shift_next = (code <= 4'd9);
            func_next  = (code >= 4'd10);
          end else begin
            deb_cnt_next = deb_cnt_reg + 1'b1;
          end
        end else begin
          state_next    = SCAN;
          scan_cnt_next = '0;
          col_next      = col_reg + 2'd1;
        end
      end
      PRESSED: begin
        if (rs_reg == 4'hF) begin
          deb_cnt_next = '0;
          state_next   = RELEASE;
        end
      end
      RELEASE: begin
        if (rs_reg == 4'hF) begin
          if (deb_cnt_reg == DEB_LAST) begin
            state_next    = SCAN;
            scan_cnt_next = '0;
            col_next      = col_reg + 2'd1;
          end else begin
            deb_cnt_next = deb_cnt_reg + 1'b1;
          end
        end else if (rs_reg == cand_pat) begin
          // Release bounce: the same key reappeared, so no new strobe.
          state_next = PRESSED;
        end else begin
          deb_cnt_next = '0;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign col_n[gi] = (col_reg != 2'(gi));
    end
  endgenerate

  assign key      = key_reg;
  assign shift    = shift_reg;
  assign func     = func_reg;
  assign key_held = (state_reg == PRESSED) || (state_reg == RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized scoreboard bench for keypad_scan: a physical keypad model drives rows,
// expected key codes are queued at press time and checked by a forked monitor.
module tb_keypad_scan;

  logic       clk;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key;
  logic       shift;
  logic       func;
  logic       key_held;

  logic [15:0] down;         // bit r*4+c set = key at row r, column c is physically pressed
  int          tests;
  int          fails;
  int          strobes;
  int unsigned exp_q[$];
  int unsigned face[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
    .key(key), .shift(shift), .func(func), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_n[c])
        for (int r = 0; r < 4; r++)
          if (down[r*4+c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    logic prev;
    int unsigned e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && (shift || func)) begin
        check("strobe_exclusive", int'(shift & func), 0);
        check("strobe_gap", int'(prev), 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got key=%0d shift=%0d func=%0d expected none", key, shift, func);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] strobe key=%0d shift=%0d func=%0d expected key=%0d", key, shift, func, e);
          check("strobe_key", int'(key), int'(e));
          check("strobe_shift", int'(shift), int'(e <= 9));
          check("strobe_func", int'(func), int'(e >= 10));
        end
        strobes++;
      end
      prev = shift | func;
    end
  endtask

  task automatic wait_strobes(input int target, input string name);
    int n = 0;
    while (strobes < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(strobes >= target), 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (key_held && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("release_done", int'(key_held), 0);
  endtask

  // Press with bounce, hold, release with chatter; one strobe expected.
  task automatic do_key(input int p, input int bounce_len, input int period,
                        input int hold, input int chatter);
    int target;
    int n;
    exp_q.push_back(face[p/4][p%4]);
    target = strobes + 1;
    for (int i = 0; i < bounce_len; i++) begin
      if (i % period == 0) down[p] = ~down[p];
      tick(1);
    end
    down[p] = 1'b1;
    wait_strobes(target, "strobe_seen");
    tick(hold);
    check("held_while_pressed", int'(key_held), 1);
    for (int i = 0; i < chatter; i++) begin
      down[p] = ~down[p];
      tick(1);
    end
    down[p] = 1'b0;
    wait_idle(n);
    check("key_retained", int'(key), int'(face[p/4][p%4]));
    check("single_strobe", strobes, target);
    tick(6);
  endtask

  initial begin
    int n;
    int s0;
    tests = 0; fails = 0; strobes = 0;
    reset = 1'b0;
    down  = '0;
    fork monitor(); join_none

    #12;
    check("rst_col", int'(col_n), 4'b1110);
    check("rst_key", int'(key), 0);
    check("rst_strobes", int'(shift | func), 0);
    check("rst_held", int'(key_held), 0);

    // Idle scan: each column for 4 clocks, in order.
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("idle_col", int'(col_n), int'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
      @(negedge clk);
    end
    check("idle_outputs", int'({key, shift, func, key_held}), 0);

    // Clean digit 5 (r1,c1).
    exp_q.push_back(face[1][1]);
    down[5] = 1'b1;
    wait_strobes(1, "clean_strobe");
    tick(10);
    check("clean_held", int'(key_held), 1);
    down[5] = 1'b0;
    wait_idle(n);
    check("clean_release_time", int'(n >= 8 && n <= 12), 1);
    check("clean_next_col", int'(col_n), 4'b1011);
    check("clean_key", int'(key), 5);
    tick(10);

    // Bouncy 0 (r3,c1), function # (r3,c2), then digit 7 (r2,c0).
    do_key(13, 20, 3, 12, 5);
    do_key(14, 0, 1, 6, 0);
    do_key(8, 0, 1, 6, 0);

    // Ghost: rows 0 and 2 low together in column 0.
    s0 = strobes;
    down[0] = 1'b1;
    down[8] = 1'b1;
    tick(60);
    check("ghost_no_strobe", strobes, s0);
    check("ghost_not_held", int'(key_held), 0);
    down = '0;
    tick(10);

    // Glitch: row low 5 clocks once column 1 is driven.
    n = 0;
    while (col_n != 4'b1101 && n < 40) begin tick(1); n++; end
    check("glitch_found_col", int'(col_n), 4'b1101);
    down[5] = 1'b1;
    n = 0;
    while (col_n == 4'b1101 && n < 40) begin
      if (n == 5) down[5] = 1'b0;
      tick(1);
      n++;
    end
    down[5] = 1'b0;
    check("glitch_col_dwell", int'(n >= 6 && n <= 12), 1);
    check("glitch_next_col", int'(col_n), 4'b1011);
    check("glitch_no_strobe", strobes, s0);
    check("glitch_not_held", int'(key_held), 0);
    tick(10);

    // Reset while key 9 (r2,c2) is held.
    exp_q.push_back(face[2][2]);
    s0 = strobes;
    down[10] = 1'b1;
    wait_strobes(s0 + 1, "rstmid_strobe");
    tick(5);
    check("rstmid_held", int'(key_held), 1);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_col", int'(col_n), 4'b1110);
    check("rstmid_key", int'(key), 0);
    check("rstmid_held_clr", int'(key_held), 0);
    check("rstmid_strobes", int'(shift | func), 0);
    down[10] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(4);
    do_key(10, 0, 1, 5, 0);

    // Random presses with random bounce and release chatter.
    for (int i = 0; i < 12; i++) begin
      do_key($urandom_range(0, 15), $urandom_range(0, 12), $urandom_range(1, 3),
             $urandom_range(2, 20), $urandom_range(0, 5));
    end

    tick(20);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner and debouncer for the alarm clock. It sits directly upstream of the digit shift register.
- It drives the keypad columns and samples the rows. Each debounced digit press (0-9) becomes a 4-bit key code plus a one-cycle shift strobe.
- Non-digit keys (A-D, *, #) produce a separate func strobe, which the mode/control logic consumes.

Parameters:
SCAN_DIV, 1000, clocks per column step; minimum 4 (covers synchronizer latency plus settling)
DEBOUNCE_CYCLES, 20000, consecutive stable clocks required to accept a press or a release; minimum 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
row_n  input  4  keypad rows, pulled up; low = key pressed in the driven column; asynchronous to clk
col_n  output  4  column drive, one-hot low; bit c low = column c driven
key  output  4  code of the last accepted key; held until the next accepted press
shift  output  1  one-cycle strobe: accepted key is a digit 0-9
func  output  1  one-cycle strobe: accepted key is 10-15
key_held  output  1  high while an accepted key remains pressed (states PRESSED and RELEASE)

Behaviour:
- Reset (reset=0, asynchronous):
  - state SCAN, column index 0, col_n=4'b1110
  - key=0, shift=0, func=0, key_held=0
  - counters 0, synchronizer flops 4'hF
  - Reset asserted mid-press aborts all state; no strobe is emitted.
- row_n passes through a 2-flop synchronizer; rs denotes the synchronized value. All decisions use rs.
- Keymap (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Codes: digits = face value, A=10, B=11, C=12, D=13, *=14, #=15.
- Candidate row pattern = rs with only the candidate row's bit low.
- SCAN:
  - Divider counts 0..SCAN_DIV-1 per column.
  - On count SCAN_DIV-1, rs is sampled:
    - Exactly one bit low: latch candidate (col, row), clear the counter, go to DEBOUNCE. The column stays driven.
    - All bits high, or more than one bit low (ghost/multi-press, ignored): advance column, wrapping 3->0.
- DEBOUNCE:
  - Column held. Each clock that rs equals the candidate pattern increments the counter.
  - Any mismatch: go to SCAN; the divider restarts and the column advances.
  - Counter reaches DEBOUNCE_CYCLES-1 with a match:
    - go to PRESSED
    - register key=code
    - in the same edge, assert shift (code<=9) or func (code>=10) for exactly one cycle
- PRESSED:
  - key_held=1, column held, no further strobes.
  - rs=4'hF: clear the counter and go to RELEASE.
  - Any other pattern, including extra keys: stay in PRESSED.
- RELEASE:
  - key_held=1. Each clock with rs=4'hF increments the counter.
  - rs shows the candidate row low again: return to PRESSED with no new strobe (release bounce).
  - Any other non-F pattern: treated as not released; counter cleared, stay in RELEASE.
  - Counter reaches DEBOUNCE_CYCLES-1: go to SCAN, key_held=0, advance column.
- General rules:
  - One strobe per physical press; no auto-repeat.
  - shift and func are never high together, and never high on consecutive cycles.
- Press latency: strobe asserts DEBOUNCE_CYCLES clocks after entering DEBOUNCE. Worst case from a stable press is 4*SCAN_DIV + DEBOUNCE_CYCLES + 2 clocks.
- Counters are sized to clog2 of the parameter and saturate at terminal count. There is no wrap-around inside a state.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_CYCLES=8 unless noted.
- Idle scan: no key. col_n cycles 1110->1101->1011->0111->1110, each pattern lasting 4 clocks. shift, func and key_held stay 0 and key stays 0.
- Clean digit: model asserts row 1 low only while column 1 is driven (key 5). Response: one shift pulse, key=4'd5, func=0. key_held=1 until release plus 8 clocks; scan then resumes at column 2.
- Bouncy press and release: key 0 (r3,c1), row toggled every 3 clocks for 20 clocks, then stable, then released with 5-clock chatter. Response: exactly one shift, key=0. No second strobe during release chatter.
- Function key: # (r3,c2) held stable. Response: one func pulse, key=4'd15, shift=0. A subsequent digit 7 press gives shift with key=7.
- Ghost and glitch:
  - Rows 0 and 2 both low in column 0: no strobe, scan continues.
  - Row low for 5 clocks in DEBOUNCE, then high: no strobe; state returns to SCAN with the column advanced.
- Reset mid-press: drop reset during PRESSED for key 9. Response: all outputs 0 and col_n=1110 immediately, without waiting for clk. After release and re-press, a normal strobe with key=9 appears.
